// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU and the ALU controller:
// ALUControl operation codes, FSM state encoding and the default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    // ALUControl encoding; 4'b1110 and 4'b1111 are undefined and yield 0.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SUB = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;
    localparam logic [3:0] ALU_MUL = 4'b1001;
    localparam logic [3:0] ALU_GEZ = 4'b1010;
    localparam logic [3:0] ALU_GTZ = 4'b1011;
    localparam logic [3:0] ALU_LEZ = 4'b1100;
    localparam logic [3:0] ALU_LTZ = 4'b1101;

    // Execute-unit FSM: single-cycle ops stay in IDLE, MUL iterates in MUL.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // True for the iterative multiply opcode.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// start latches the operands; each following edge retires one multiplier bit.
// done/product are combinational during the final iteration so the caller can
// register the result on that same edge.
// Optional: ALU_MUL_EARLY_TERM_EN ends the run on the first edge at which the
// remaining multiplier bits are all zero (minimum one iteration).
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic [WIDTH-1:0] addend_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             last_s;

    // One iteration: add the shifted multiplicand when the multiplier LSB is set,
    // and decide whether this is the final iteration.
    always_comb begin
        addend_s   = {WIDTH{1'b0}};
        acc_next_s = acc_r;
        last_s     = 1'b0;
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        acc_next_s = acc_r + addend_s;
`ifdef ALU_MUL_EARLY_TERM_EN
        last_s = (cnt_r == CNT_LAST) || (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
        last_s = (cnt_r == CNT_LAST);
`endif
    end

    assign busy    = busy_r;
    assign done    = busy_r && last_s;
    assign product = acc_next_s;

    // Operand latch on start, then shift/accumulate until the final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake on both sides.
// Single-cycle ops complete with latency 1; MUL is handed to alu_mul_iter and
// the unit stalls (InReady=0, Busy=1) until it completes.
// Optional macro ALU_MUL_EARLY_TERM_EN (in alu_mul_iter) shortens MUL latency only.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               InValid,
    output logic               InReady,
    input  logic [3:0]         ALUControl,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic               Busy
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    alu_state_e       state_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             mul_start_s;
    logic             mul_busy_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             a_neg_s;
    logic             a_zero_s;

    // Handshake: accept only in IDLE when the result slot is free or being drained.
    always_comb begin
        in_ready_s  = 1'b0;
        accept_s    = 1'b0;
        mul_start_s = 1'b0;
        if (state_r == ST_IDLE) begin
            in_ready_s = !out_valid_r || OutReady;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s    = InValid && in_ready_s;
        mul_start_s = accept_s && is_mul_op(ALUControl);
    end

    // Single-cycle datapath; undefined codes and MUL (handled by the engine) give 0.
    always_comb begin
        alu_res_s = ZERO_W;
        a_neg_s   = A[WIDTH-1];
        a_zero_s  = (A == ZERO_W);
        case (ALUControl)
            ALU_AND: alu_res_s = A & B;
            ALU_OR:  alu_res_s = A | B;
            ALU_ADD: alu_res_s = A + B;
            ALU_XOR: alu_res_s = A ^ B;
            ALU_NOR: alu_res_s = ~(A | B);
            ALU_SLL: alu_res_s = B << Shamt;
            ALU_SRL: alu_res_s = B >> Shamt;
            ALU_SUB: alu_res_s = A - B;
            ALU_SLT: alu_res_s = ($signed(A) < $signed(B)) ? ONE_W : ZERO_W;
            ALU_GEZ: alu_res_s = (!a_neg_s) ? ONE_W : ZERO_W;
            ALU_GTZ: alu_res_s = (!a_neg_s && !a_zero_s) ? ONE_W : ZERO_W;
            ALU_LEZ: alu_res_s = (a_neg_s || a_zero_s) ? ONE_W : ZERO_W;
            ALU_LTZ: alu_res_s = a_neg_s ? ONE_W : ZERO_W;
            default: alu_res_s = ZERO_W;
        endcase
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (Clk),
        .rst_n   (Rst),
        .start   (mul_start_s),
        .a       (A),
        .b       (B),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // FSM plus output register: capture results, hold under back-pressure, drop on consume.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= ZERO_W;
            zero_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mul_start_s) begin
                        state_r     <= ST_MUL;
                        out_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        out_valid_r <= 1'b1;
                        result_r    <= alu_res_s;
                        zero_r      <= (alu_res_s == ZERO_W);
                    end else if (out_valid_r && OutReady) begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b1;
                        result_r    <= mul_product_s;
                        zero_r      <= (mul_product_s == ZERO_W);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign InReady   = in_ready_s;
    assign OutValid  = out_valid_r;
    assign ALUResult = result_r;
    assign Zero      = zero_r;
    assign Busy      = mul_busy_s;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected results into a
// queue, a monitor pops and compares on every output transfer.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        InValid;
    logic        InReady;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Busy;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .InValid    (InValid),
        .InReady    (InReady),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Shamt      (Shamt),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Rst === 1'b1 && OutValid === 1'b1 && OutReady === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", ALUResult, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("result", ALUResult, e.res);
                    check("zero", 32'(Zero), 32'(e.zero));
                end
            end
        end
    end

    // Present one op (called at posedge+1), wait for acceptance, deassert InValid.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] exp, input bit push,
                         output int waited);
        exp_t e;
        logic acc;
        ALUControl = op; A = a; B = b; Shamt = sh; InValid = 1'b1;
        if (push) begin
            e.res  = exp;
            e.zero = (exp == 32'd0);
            exp_q.push_back(e);
        end
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited < 100) begin
            @(negedge Clk);
            acc = InReady;
            @(posedge Clk);
            #1;
            if (!acc) waited++;
        end
        InValid = 1'b0;
        check("accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        OutReady = 1'b1;
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // MUL with latency, Busy and InReady checks; operands are scrambled after accept.
    task automatic mul_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input int exp_lat);
        int w;
        int n;
        int viol;
        issue(ALU_MUL, a, b, 5'd0, exp, 1'b1, w);
        A = 32'hA5A5_5A5A; B = 32'h0;
        n = 0;
        viol = 0;
        while (OutValid !== 1'b1 && n < 100) begin
            if (!(Busy === 1'b1 && InReady === 1'b0)) viol++;
            @(posedge Clk);
            #1;
            n++;
        end
        check("mul_latency", 32'(n), 32'(exp_lat));
        check("mul_busy_stall", 32'(viol), 32'd0);
        check("mul_busy_done", 32'(Busy), 32'd0);
    endtask

    initial begin
        int w;
        int viol;
        Rst = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        ALUControl = 4'd0; A = 32'd0; B = 32'd0; Shamt = 5'd0;

        repeat (3) @(posedge Clk);
        #1;
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", 32'(Zero), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        check("idle_inready", 32'(InReady), 32'd1);
        check("idle_outvalid", 32'(OutValid), 32'd0);
        check("idle_result", ALUResult, 32'd0);

        // Single-cycle ops, issued back to back.
        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1, w);
        check("add_latency1", 32'(OutValid), 32'd1);
        issue(ALU_SUB, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1, w);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b1, w);
        issue(ALU_SRL, 32'h0, 32'h8000_0000, 5'd31, 32'h1, 1'b1, w);
        issue(ALU_SLL, 32'h0, 32'h1, 5'd31, 32'h8000_0000, 1'b1, w);
        issue(ALU_NOR, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b1, w);
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'h0, 1'b1, w);
        issue(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0, 1'b1, w);
        issue(ALU_GEZ, 32'h0, 32'h0, 5'd0, 32'h1, 1'b1, w);
        issue(ALU_GTZ, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, w);
        issue(ALU_LEZ, 32'd5, 32'h0, 5'd0, 32'h0, 1'b1, w);
        issue(ALU_LTZ, 32'h8000_0000, 32'h0, 5'd0, 32'h1, 1'b1, w);
        issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b1, w);
        check("b2b_and_wait", 32'(w), 32'd0);
        issue(ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b1, w);
        check("b2b_or_wait", 32'(w), 32'd0);
        issue(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b1, w);
        check("b2b_xor_wait", 32'(w), 32'd0);
        drain();

        // Multiply: full-length vs early-terminating latency.
`ifdef ALU_MUL_EARLY_TERM_EN
        mul_run(32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 3);
        drain();
        mul_run(32'd5, 32'd3, 32'd15, 2);
        drain();
        mul_run(32'h1234_5678, 32'd0, 32'd0, 1);
        drain();
        mul_run(32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 17);
`else
        mul_run(32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32);
        drain();
        mul_run(32'd5, 32'd3, 32'd15, 32);
        drain();
        mul_run(32'h1234_5678, 32'd0, 32'd0, 32);
        drain();
        mul_run(32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 32);
`endif
        drain();

        // Back-pressure: hold 1+2 for 4 cycles with 4+4 pending.
        OutReady = 1'b0;
        issue(ALU_ADD, 32'd1, 32'd2, 5'd0, 32'd3, 1'b1, w);
        begin
            exp_t e;
            e.res = 32'd8; e.zero = 1'b0;
            exp_q.push_back(e);
        end
        ALUControl = ALU_ADD; A = 32'd4; B = 32'd4; InValid = 1'b1;
        viol = 0;
        repeat (4) begin
            @(negedge Clk);
            if (!(ALUResult === 32'd3 && Zero === 1'b0 && InReady === 1'b0 && OutValid === 1'b1))
                viol++;
            @(posedge Clk);
            #1;
        end
        check("bp_hold", 32'(viol), 32'd0);
        OutReady = 1'b1;
        @(negedge Clk);
        check("bp_release_inready", 32'(InReady), 32'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        check("bp_same_edge_valid", 32'(OutValid), 32'd1);
        check("bp_same_edge_result", ALUResult, 32'd8);
        drain();

        // Reset in the middle of a multiply: abort, no result ever emitted.
        issue(ALU_MUL, 32'd3, 32'd5, 5'd0, 32'd15, 1'b0, w);
        @(posedge Clk);
        #1;
        check("mid_mul_busy", 32'(Busy), 32'd1);
        #2;
        Rst = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_outvalid", 32'(OutValid), 32'd0);
        check("abort_result", ALUResult, 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        viol = 0;
        repeat (40) begin
            @(negedge Clk);
            if (OutValid !== 1'b0 || Busy !== 1'b0) viol++;
        end
        check("abort_no_output", 32'(viol), 32'd0);
        @(posedge Clk);
        #1;
        issue(ALU_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1'b1, w);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU downstream of the ALU controller; consumes its 4-bit ALUControl plus operands and produces ALUResult/Zero for the MEM stage and branch logic.
- Single-cycle ops complete in 1 cycle; MUL runs on an iterative shift-add engine over WIDTH cycles.
- Valid/ready handshake on input and output, so the pipeline stalls cleanly during MUL or downstream back-pressure.

Parameters:
WIDTH, 32, operand/result width
SHAMT_W, 5, shift-amount width (log2 WIDTH)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
InValid  in  1  operation presented
InReady  out  1  unit can accept this cycle
ALUControl  in  4  operation code (encoding in package)
A  in  WIDTH  operand A (rs)
B  in  WIDTH  operand B (rt or sign/zero-extended immediate)
Shamt  in  SHAMT_W  shift amount
OutValid  out  1  result register holds valid data
OutReady  in  1  consumer takes result this cycle
ALUResult  out  WIDTH  registered result
Zero  out  1  registered (ALUResult == 0)
Busy  out  1  MUL engine active

Behaviour:
- Encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLL, 0110 SRL, 0111 SUB, 1000 SLT, 1001 MUL, 1010 GEZ, 1011 GTZ, 1100 LEZ, 1101 LTZ. 1110 and 1111 are undefined.
- Reset: state IDLE, OutValid=0, ALUResult=0, Zero=0, Busy=0, MUL counter/accumulator=0.
- States:
  - IDLE: accept when InValid && InReady.
  - MUL: iterating; moves to IDLE after the final iteration.
- InReady = (state==IDLE) && (!OutValid || OutReady), combinational. Accept and consume in the same cycle are allowed, giving throughput 1/cycle for single-cycle ops.
- Single-cycle op accepted at edge k: ALUResult/Zero/OutValid are valid after edge k (latency 1).
- MUL accepted at edge k:
  - Latch A, B; enter MUL; Busy=1.
  - Each edge adds the shifted multiplicand when the multiplier LSB is 1.
  - After edge k+WIDTH: ALUResult = low WIDTH bits of A*B (signedness irrelevant for the low half); OutValid=1, Busy=0, state IDLE.
  - OutValid=0 throughout MUL; InReady=0 throughout MUL.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLL = B<<Shamt; SRL = B>>Shamt, logical.
  - SLT = (signed A < signed B) ? 1 : 0.
  - GEZ/GTZ/LEZ/LTZ = signed compare of A against 0, result 1/0.
- Zero = (next ALUResult == 0), registered together with ALUResult. BEQ/BNE use SUB and Zero.
- Undefined codes: result 0, Zero=1, latency 1; no hang.
- Back-pressure: while OutValid && !OutReady, ALUResult/Zero are held stable and InReady=0.
- OutValid falls after the consume edge unless a new op is accepted on the same edge.
- Reset mid-MUL: asynchronous abort to the reset values above. The aborted operation never produces OutValid.
- Inputs are sampled only on the accept edge. Operand changes during MUL have no effect.

Optional Feature:
- Macro: ALU_MUL_EARLY_TERM_EN.
- Defined: MUL finishes on the first edge at which the remaining multiplier bits are all zero, minimum 1 cycle. For example, B=3 completes after 2 edges; B=0 completes after 1 edge.
- Undefined: MUL always takes exactly WIDTH cycles.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package `alu_pkg`: ALUControl localparams (ALU_AND … ALU_LTZ), FSM state localparams (ST_IDLE, ST_MUL), default WIDTH. The ALU controller imports the same constants.
- One sub-module: `alu_mul_iter` (shift-add multiplier with start/done, counter, accumulator).
- The combinational ALU datapath, handshake and output register stay in the top.

Test Plan:
- Reset release, InValid=0 -> OutValid=0, ALUResult=0, InReady=1; assert Rst low mid-MUL -> Busy=0 and OutValid=0 immediately, no result ever emitted.
- ADD A=0x7FFFFFFF, B=1 -> after 1 cycle ALUResult=0x80000000, Zero=0; SUB A=5, B=5 -> ALUResult=0, Zero=1.
- SLT A=0xFFFFFFFF, B=1 -> 1; SRL B=0x80000000, Shamt=31 -> 1; NOR A=0, B=0 -> 0xFFFFFFFF; code 1111 -> 0 with Zero=1.
- MUL A=0xFFFFFFFF(-1), B=7 -> InReady=0 and Busy=1 for 32 cycles, then ALUResult=0xFFFFFFF9; with ALU_MUL_EARLY_TERM_EN, OutValid rises after 3 cycles.
- Back-pressure: ADD 1+2 with OutReady=0 for 4 cycles -> ALUResult=3 held, InReady=0; raise OutReady with ADD 4+4 pending -> accepted same edge, next result 8.
- Back-to-back AND/OR/XOR with OutReady=1 -> one result per cycle, in order, no bubbles.
